// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Plays a per-event note sequence as a PWM-modulated square wave
//            for the PmodAMP2, with priority pre-emption, latched volume and
//            amplifier-enable control.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int N_EVENTS = 3,
    parameter int NOTES    = 4,
    parameter int HP_W     = 16,
    parameter logic [N_EVENTS*NOTES*HP_W-1:0] NOTE_TABLE = '0,
    parameter int NOTE_LEN = 12_500_000,
    parameter int GAP_LEN  = 500_000,
    parameter int PWM_BITS = 8,
    localparam int EV_W    = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_EVENTS-1:0] event_req,
    input  logic [PWM_BITS-1:0] volume,
    output logic                audio_pwm,
    output logic                amp_en,
    output logic                busy,
    output logic [EV_W-1:0]     active_event,
    output logic                done
);

    localparam int NI_W   = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int TI_W   = (N_EVENTS * NOTES > 1) ? $clog2(N_EVENTS * NOTES) : 1;
    localparam int NOTE_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
    localparam int GAP_W  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [NOTE_W-1:0] c_NOTE_LAST = NOTE_W'(NOTE_LEN - 1);
    localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [NI_W-1:0]   c_IDX_LAST  = NI_W'(NOTES - 1);
    localparam bit                c_NO_GAP    = (GAP_LEN == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [N_EVENTS-1:0] r_req_q;
    logic                r_rst_mask;
    logic [EV_W-1:0]     r_ev;
    logic [PWM_BITS-1:0] r_vol_q;
    logic [NI_W-1:0]     r_note_idx;
    logic [NOTE_W-1:0]   r_note_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [HP_W-1:0]     r_hp_cnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_audio;
    logic                r_amp_en;
    logic                r_done;

    logic [N_EVENTS-1:0] w_edge;
    logic                w_edge_any;
    logic [EV_W-1:0]     w_edge_idx;
    logic                w_note_end;
    logic                w_gap_end;
    logic                w_last_note;
    logic                w_preempt;
    logic                w_start;
    logic                w_adv;
    logic                w_note_start;
    logic [TI_W-1:0]     w_entry;
    logic [HP_W-1:0]     w_hp;
    logic [HP_W-1:0]     w_table [N_EVENTS*NOTES];

    // Unpack the flat note table into an indexable array of half-periods
    for (genvar gi = 0; gi < N_EVENTS * NOTES; gi++) begin : g_table
        assign w_table[gi] = NOTE_TABLE[gi*HP_W +: HP_W];
    end

    // The first sampled cycle after reset is masked so a request held through
    // reset must fall and rise again before it can start a sequence.
    assign w_edge     = event_req & ~r_req_q & {N_EVENTS{~r_rst_mask}};
    assign w_edge_any = |w_edge;

    // Lowest-index edge wins: scan from the top so the lowest hit is kept
    always_comb begin
        w_edge_idx = '0;
        for (int i = N_EVENTS - 1; i >= 0; i--) begin
            if (w_edge[i]) begin
                w_edge_idx = EV_W'(i);
            end
        end
    end

    assign w_note_end   = (r_state == S_PLAY) && (r_note_cnt == c_NOTE_LAST);
    assign w_gap_end    = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_last_note  = (r_note_idx == c_IDX_LAST);
    assign w_preempt    = (r_state != S_IDLE) && w_edge_any && (w_edge_idx < r_ev);
    assign w_start      = ((r_state == S_IDLE) && w_edge_any) || w_preempt;
    assign w_adv        = !w_preempt && (w_gap_end ||
                          (w_note_end && !w_last_note && c_NO_GAP));
    assign w_note_start = w_start || w_adv;

    assign w_entry = TI_W'(r_ev) * TI_W'(NOTES) + TI_W'(r_note_idx);
    assign w_hp    = w_table[w_entry];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; pre-emption always restarts in PLAY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_edge_any) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (w_preempt) begin
                    w_state_nxt = S_PLAY;
                end else if (w_note_end) begin
                    if (w_last_note)   w_state_nxt = S_IDLE;
                    else if (c_NO_GAP) w_state_nxt = S_PLAY;
                    else               w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_preempt || w_gap_end) w_state_nxt = S_PLAY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy         = (r_state != S_IDLE);
        active_event = busy ? r_ev : '0;
    end

    // Sequence datapath: event/volume latch, note, gap and tone counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q    <= '0;
            r_rst_mask <= 1'b1;
            r_ev       <= '0;
            r_vol_q    <= '0;
            r_note_idx <= '0;
            r_note_cnt <= '0;
            r_gap_cnt  <= '0;
            r_hp_cnt   <= '0;
            r_phase    <= 1'b0;
            r_pwm_cnt  <= '0;
        end else begin
            r_req_q    <= event_req;
            r_rst_mask <= 1'b0;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;

            if (w_start) begin
                r_ev       <= w_edge_idx;
                r_vol_q    <= volume;
                r_note_idx <= '0;
            end else if (w_adv) begin
                r_note_idx <= r_note_idx + 1'b1;
            end

            if (w_note_start || w_note_end || r_state != S_PLAY) begin
                r_note_cnt <= '0;
            end else begin
                r_note_cnt <= r_note_cnt + 1'b1;
            end

            if (r_state == S_GAP && !w_gap_end && !w_preempt) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_note_start) begin
                r_hp_cnt <= '0;
                r_phase  <= 1'b0;
            end else if (r_state == S_PLAY) begin
                if (w_hp == '0) begin
                    r_hp_cnt <= '0;
                    r_phase  <= 1'b0;
                end else if (r_hp_cnt == w_hp - HP_W'(1)) begin
                    r_hp_cnt <= '0;
                    r_phase  <= ~r_phase;
                end else begin
                    r_hp_cnt <= r_hp_cnt + 1'b1;
                end
            end
        end
    end

    // Registered audio, amplifier enable and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_audio  <= 1'b0;
            r_amp_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_audio  <= (r_state == S_PLAY) && r_phase && (r_pwm_cnt < r_vol_q);
            r_amp_en <= (w_state_nxt != S_IDLE);
            r_done   <= w_note_end && w_last_note && !w_preempt;
        end
    end

    assign audio_pwm = r_audio;
    assign amp_en    = r_amp_en;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Purpose  : Self-checking bench for tone_sequencer using a time-based
//            reference model (position in sequence derived arithmetically).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int NOTE_LEN = 64;
    localparam int GAP_LEN  = 8;
    localparam int NOTES    = 2;
    localparam int PERIOD   = NOTE_LEN + GAP_LEN;
    localparam int TOTAL    = NOTES * NOTE_LEN + (NOTES - 1) * GAP_LEN;
    // event 0 = {4, 8}, event 1 = {2, 0}, event 2 = {16, 16}
    localparam logic [47:0] TABLE = {8'd16, 8'd16, 8'd0, 8'd2, 8'd8, 8'd4};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] event_req = 3'b000;
    logic [3:0] volume = 4'd0;
    logic       audio_pwm, amp_en, busy, done;
    logic [1:0] active_event;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit       m_busy;
    int       m_ev, m_vol, m_t, m_cyc;
    bit [2:0] m_prev;
    bit       exp_audio, exp_done;
    int       g_tick = 0;
    int       done_at = -1;
    int       audio_highs = 0;

    tone_sequencer #(
        .N_EVENTS(3), .NOTES(NOTES), .HP_W(8), .NOTE_TABLE(TABLE),
        .NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN), .PWM_BITS(4)
    ) dut (
        .clk(clk), .reset(reset), .event_req(event_req), .volume(volume),
        .audio_pwm(audio_pwm), .amp_en(amp_en), .busy(busy),
        .active_event(active_event), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int hp_of(int ev, int n);
        case (ev * 2 + n)
            0: return 4;
            1: return 8;
            2: return 2;
            3: return 0;
            default: return 16;
        endcase
    endfunction

    // tone level at time t (cycles since sequence start): 1 only while a note sounds high
    function automatic bit tone_high(int ev, int t);
        int off, n, hp;
        off = t % PERIOD;
        n   = t / PERIOD;
        if (off >= NOTE_LEN) return 1'b0;
        hp = hp_of(ev, n);
        if (hp == 0) return 1'b0;
        return ((off / hp) % 2) == 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ev = 0; m_vol = 0; m_t = 0; m_cyc = 0;
        m_prev = 3'b111;
    endtask

    // Advance one clock: predict from pre-edge state, then compare after the edge
    task automatic tick();
        bit [2:0] e;
        int w;
        e = event_req & ~m_prev;
        w = -1;
        for (int i = 2; i >= 0; i--) if (e[i]) w = i;
        exp_audio = m_busy && tone_high(m_ev, m_t) && ((m_cyc % 16) < m_vol);
        exp_done  = 0;
        if (w >= 0 && (!m_busy || w < m_ev)) begin
            m_busy = 1; m_ev = w; m_vol = int'(volume); m_t = 0;
        end else if (m_busy && m_t == TOTAL - 1) begin
            m_busy = 0; exp_done = 1;
        end else if (m_busy) begin
            m_t++;
        end
        m_prev = event_req;
        m_cyc++;
        @(posedge clk);
        #1;
        g_tick++;
        if (done === 1'b1) done_at = g_tick;
        if (audio_pwm === 1'b1) audio_highs++;
        check("audio_pwm", {31'd0, audio_pwm}, {31'd0, exp_audio});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("amp_en", {31'd0, amp_en}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, exp_done});
        check("active_event", {30'd0, active_event}, m_busy ? m_ev : 0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(string tag);
        check(tag, {27'd0, audio_pwm, amp_en, busy, done, active_event}, 32'd0);
    endtask

    int start_tick;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        ticks(3);

        // 1: event 0, full volume, exact completion time
        event_req = 3'b001; volume = 4'd15;
        tick();
        start_tick = g_tick;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_active", {30'd0, active_event}, 32'd0);
        volume = 4'd3;
        ticks(140);
        check("t1_done_latency", done_at - start_tick, TOTAL);

        // 2: event 1 at half volume; note 1 is a rest
        event_req = 3'b000; tick();
        event_req = 3'b010; volume = 4'd8;
        ticks(140);

        // 3: cascading pre-emption 2 -> 1 -> 0
        event_req = 3'b000; tick();
        event_req = 3'b100; volume = 4'd12; ticks(5);
        check("t3_active2", {30'd0, active_event}, 32'd2);
        event_req = 3'b110; volume = 4'd10; tick();
        check("t3_active1", {30'd0, active_event}, 32'd1);
        event_req = 3'b111; volume = 4'd6; tick();
        check("t3_active0", {30'd0, active_event}, 32'd0);
        done_at = -1;
        start_tick = g_tick;
        ticks(150);
        check("t3_done_latency", done_at - start_tick, TOTAL);

        // 4: simultaneous edges, then held with no retrigger
        event_req = 3'b000; tick();
        event_req = 3'b011; volume = 4'd9;
        ticks(150);
        check("t4_no_retrigger", {31'd0, busy}, 32'd0);

        // 5: zero volume latched; later volume changes ignored
        event_req = 3'b000; tick();
        event_req = 3'b100; volume = 4'd0; tick();
        audio_highs = 0;
        volume = 4'd15;
        ticks(140);
        check("t5_silent", audio_highs, 32'd0);

        // 6: reset mid-note with request held through reset
        event_req = 3'b000; tick();
        event_req = 3'b001; volume = 4'd15;
        ticks(31);
        reset = 1'b1;
        #1;
        check_all_zero("t6_reset_async");
        @(posedge clk); #1;
        check_all_zero("t6_reset_held");
        reset = 1'b0;
        model_reset();
        ticks(10);
        check("t6_no_restart", {31'd0, busy}, 32'd0);
        event_req = 3'b000; tick();
        event_req = 3'b001; tick();
        check("t6_restart", {31'd0, busy}, 32'd1);
        ticks(20);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 23) == 0) event_req = 3'($urandom_range(0, 7));
            volume = 4'($urandom_range(0, 15));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
